sn76489_bus_writer: RTL and testbench
=====================================

SN76489_BUS_WRITER -- requirements
Module: sn76489_bus_writer

Interface
REQ-001 Parameter WAIT_MIN, default 2: minimum cycles the write strobes are held low per byte; legal range 1..255.
REQ-002 Parameter TIMEOUT, default 255: maximum strobe-low cycles before a write is aborted; must exceed WAIT_MIN.
REQ-003 Port CLK  in  1  clock; all logic is on posedge.
REQ-004 Port nRST  in  1  reset: synchronous, active-low, sampled on posedge CLK.
REQ-005 Port req_valid  in  1  host presents a register-write command.
REQ-006 Port req_ready  out  1  writer can accept a command; high only in IDLE.
REQ-007 Port req_chan  in  2  channel 0..2 tone, 3 noise.
REQ-008 Port req_vol  in  1  1 = attenuation write, 0 = tone/noise write.
REQ-009 Port req_data  in  10  tone period [9:0]; attenuation [3:0]; noise control [2:0].
REQ-010 Port D  out  8  chip data bus.
REQ-011 Port nCE  out  1  chip enable, active-low.
REQ-012 Port nWE  out  1  write enable, active-low; always equal to nCE.
REQ-013 Port READY  in  1  chip ready; high = previous write absorbed.
REQ-014 Port busy  out  1  high in every state except IDLE.
REQ-015 Port err  out  1  one-cycle pulse on write timeout.

Function
REQ-016 Command accepted on a posedge with req_valid and req_ready high; chan, vol and data are registered at acceptance and ignored afterwards.
REQ-017 Latch byte: {1, chan[1:0], vol, nib}; nib = data[3:0] if vol=1 or chan<3; nib = {0, data[2:0]} if vol=0 and chan=3.
REQ-018 Data byte {0, 0, data[9:4]} is sent after the latch byte only when vol=0 and chan<3; all other commands send one byte.
REQ-019 FSM states IDLE, SETUP, STROBE, RECOVER; acceptance moves IDLE->SETUP.
REQ-020 SETUP, one cycle: D driven with the current byte, nCE/nWE high; then ->STROBE.
REQ-021 STROBE: nCE/nWE low, D stable; exit to RECOVER on the first cycle where strobe-low count >= WAIT_MIN and READY=1.
REQ-022 RECOVER, one cycle: strobes high, D held; then ->SETUP if a data byte is pending, else ->IDLE.
REQ-023 Timing: accept at cycle 0, SETUP at 1, strobe low at 2..1+WAIT_MIN when READY is high, RECOVER at 2+WAIT_MIN, req_ready high at 3+WAIT_MIN for single-byte commands.
REQ-024 Timeout: if the strobe-low count reaches TIMEOUT without exit, strobes go high next cycle, err pulses that cycle, any pending data byte is dropped, and the FSM goes ->IDLE.
REQ-025 READY low in IDLE or SETUP has no effect; only STROBE samples it.
REQ-026 req_valid outside IDLE is ignored; no queueing, no loss of an accepted command except on timeout or reset.
REQ-027 Strobe counter is 8 bits, cleared on entry to STROBE, and saturates rather than wrapping.

Reset
REQ-028 While nRST=0 at a posedge: state = IDLE, nCE = nWE = 1, D = 0x00, busy = 0, err = 0, counter = 0, pending flag = 0.
REQ-029 req_ready is 0 in any cycle where nRST is low, and 1 on the first cycle after release.
REQ-030 Reset asserted mid-STROBE releases the strobes on the next posedge; the interrupted command is discarded.

Structure
REQ-031 Shared package sn76489_pkg holds the state enum, channel constants (CH_NOISE=3), and the latch/data byte field positions used by both this writer and the chip model.
REQ-032 One sub-module, sn76489_byte_fmt: combinational formatting of chan/vol/data into latch byte, data byte and two_byte flag.

Verification
REQ-033 Tone: chan0, vol0, data 0x3FE with READY=1 -> D=0x8E strobed, then D=0x3F strobed, each strobe low exactly 2 cycles; req_ready returns at cycle 9.
REQ-034 Volume: chan2, vol1, data 0x005 -> single byte 0xD5; req_ready returns at cycle 5.
REQ-035 Noise: chan3, vol0, data 0x3F5 -> single byte 0xE5; upper data bits are ignored.
REQ-036 READY held low 10 cycles into STROBE, then high -> strobe-low lasts 11 cycles, byte completes, err stays 0.
REQ-037 READY stuck low -> strobes release after 255 low cycles, err is high for exactly 1 cycle, the data byte is never sent, and req_ready returns.
REQ-038 nRST pulsed low during the first STROBE of a tone write -> nCE/nWE/D = 1/1/0x00 next cycle, no data byte follows, and a new request is accepted on the cycle after release.

Source files
------------

// File: rtl/sn76489_pkg.sv
// sn76489_pkg: shared FSM state, channel constants and register-byte field layout
// for the SN76489 bus writer and chip model.
package sn76489_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_RECOVER
   } state_t;

   localparam logic [1:0] CH_TONE0 = 2'd0;
   localparam logic [1:0] CH_TONE1 = 2'd1;
   localparam logic [1:0] CH_TONE2 = 2'd2;
   localparam logic [1:0] CH_NOISE = 2'd3;

   // Latch byte: {1, chan[1:0], vol, nib[3:0]}; data byte: {0, 0, period[9:4]}
   localparam int LATCH_BIT  = 7;
   localparam int CHAN_LSB   = 5;
   localparam int VOL_BIT    = 4;
   localparam int NIB_W      = 4;
   localparam int NOISE_W    = 3;
   localparam int PAYLOAD_W  = 6;

endpackage

// File: rtl/sn76489_byte_fmt.sv
// sn76489_byte_fmt: combinational formatting of a register-write command into
// the latch byte, the optional tone-period data byte and the two-byte flag.
module sn76489_byte_fmt
   import sn76489_pkg::*;
(
   input  logic [1:0] i_chan,
   input  logic       i_vol,
   input  logic [9:0] i_data,
   output logic [7:0] o_latch,
   output logic [7:0] o_data,
   output logic       o_two_byte
);

   logic       w_noise_ctl;
   logic [3:0] w_nib;

   // Noise control only carries three bits; the top nibble bit must be zero
   assign w_noise_ctl = !i_vol && i_chan == CH_NOISE;
   assign w_nib       = w_noise_ctl ? {1'b0, i_data[NOISE_W-1:0]} : i_data[NIB_W-1:0];

   always_comb begin
      o_latch                  = 8'h00;
      o_latch[LATCH_BIT]       = 1'b1;
      o_latch[CHAN_LSB +: 2]   = i_chan;
      o_latch[VOL_BIT]         = i_vol;
      o_latch[NIB_W-1:0]       = w_nib;
   end

   assign o_data     = {2'b00, i_data[NIB_W +: PAYLOAD_W]};
   assign o_two_byte = !i_vol && i_chan != CH_NOISE;

endmodule

// File: rtl/sn76489_bus_writer.sv
// sn76489_bus_writer: turns host register-write commands into SN76489 bus cycles
// (SETUP / STROBE / RECOVER per byte) with READY handshake and strobe timeout.
module sn76489_bus_writer
   import sn76489_pkg::*;
#(
   parameter int WAIT_MIN = 2,
   parameter int TIMEOUT  = 255
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_chan,
   input  logic       req_vol,
   input  logic [9:0] req_data,
   output logic [7:0] D,
   output logic       nCE,
   output logic       nWE,
   input  logic       READY,
   output logic       busy,
   output logic       err
);

   localparam logic [8:0] LP_WAIT    = 9'(WAIT_MIN);
   localparam logic [8:0] LP_TIMEOUT = 9'(TIMEOUT);

   state_t     r_state;
   logic [7:0] r_cnt;
   logic [7:0] r_data_byte;
   logic       r_pend;

   logic [7:0] w_latch;
   logic [7:0] w_data;
   logic       w_two_byte;
   logic [8:0] w_low;
   logic       w_done;
   logic       w_tmo;
   logic       w_accept;

   sn76489_byte_fmt u_fmt (
      .i_chan     (req_chan),
      .i_vol      (req_vol),
      .i_data     (req_data),
      .o_latch    (w_latch),
      .o_data     (w_data),
      .o_two_byte (w_two_byte)
   );

   // r_cnt counts completed low cycles, so w_low includes the current one
   assign w_low     = {1'b0, r_cnt} + 9'd1;
   assign w_done    = w_low >= LP_WAIT && READY;
   assign w_tmo     = w_low >= LP_TIMEOUT;
   assign req_ready = nRST && r_state == ST_IDLE;
   assign w_accept  = req_valid && req_ready;
   assign busy      = r_state != ST_IDLE;
   assign nWE       = nCE;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 8'h00;
         r_data_byte <= 8'h00;
         r_pend      <= 1'b0;
         D           <= 8'h00;
         nCE         <= 1'b1;
         err         <= 1'b0;
      end else begin
         err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state     <= ST_SETUP;
                  D           <= w_latch;
                  r_data_byte <= w_data;
                  r_pend      <= w_two_byte;
               end
            end
            ST_SETUP: begin
               r_state <= ST_STROBE;
               r_cnt   <= 8'h00;
               nCE     <= 1'b0;
            end
            ST_STROBE: begin
               if (w_done) begin
                  r_state <= ST_RECOVER;
                  nCE     <= 1'b1;
               end else if (w_tmo) begin
                  r_state <= ST_IDLE;
                  r_pend  <= 1'b0;
                  nCE     <= 1'b1;
                  err     <= 1'b1;
               end else begin
                  r_cnt <= w_low[8] ? 8'hFF : w_low[7:0];
               end
            end
            ST_RECOVER: begin
               if (r_pend) begin
                  r_state <= ST_SETUP;
                  D       <= r_data_byte;
                  r_pend  <= 1'b0;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sn76489_bus_writer.sv
// tb_sn76489_bus_writer: directed and randomized register writes against a
// cycle-timeline reference model derived from the bus-write rules.
module tb_sn76489_bus_writer;

   localparam int WAIT_MIN = 2;
   localparam int TIMEOUT  = 255;

   logic       CLK = 1'b0;
   logic       nRST;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_chan;
   logic       req_vol;
   logic [9:0] req_data;
   logic [7:0] D;
   logic       nCE;
   logic       nWE;
   logic       READY;
   logic       busy;
   logic       err;

   int checks = 0;
   int errors = 0;

   sn76489_bus_writer #(.WAIT_MIN(WAIT_MIN), .TIMEOUT(TIMEOUT)) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_chan  (req_chan),
      .req_vol   (req_vol),
      .req_data  (req_data),
      .D         (D),
      .nCE       (nCE),
      .nWE       (nWE),
      .READY     (READY),
      .busy      (busy),
      .err       (err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issues one command (caller guarantees req_ready is high) and checks every
   // cycle until the model says the writer is idle again. READY stays low for
   // the first k low cycles of each byte, random whenever strobes are high.
   task automatic run_cmd(input logic [1:0] ch, input logic v, input logic [9:0] dat, input int k);
      logic [7:0] exp_b[$];
      int len, per, nb, rdy_c, idx, p;
      bit tmo, strobing;
      exp_b.push_back(8'(128 + int'(ch) * 32 + int'(v) * 16 +
                         ((!v && ch == 2'd3) ? int'(dat) % 8 : int'(dat) % 16)));
      if (!v && ch != 2'd3) exp_b.push_back(8'(int'(dat) / 16));
      len = (k + 1 > WAIT_MIN) ? k + 1 : WAIT_MIN;
      tmo = len > TIMEOUT;
      if (tmo) begin
         len = TIMEOUT;
         while (exp_b.size() > 1) void'(exp_b.pop_back());
      end
      nb    = exp_b.size();
      per   = len + 2;
      rdy_c = tmo ? TIMEOUT + 2 : nb * per + 1;
      req_chan  = ch;
      req_vol   = v;
      req_data  = dat;
      req_valid = 1'b1;
      for (int c = 1; c <= rdy_c; c++) begin
         @(negedge CLK);
         if (c == 1) begin
            req_valid = 1'b0;
            req_chan  = 2'($urandom);
            req_vol   = 1'($urandom);
            req_data  = 10'($urandom);
         end
         if (c == 2) req_valid = 1'b1;
         if (c == 3) req_valid = 1'b0;
         idx = (c - 1) / per;
         if (idx > nb - 1) idx = nb - 1;
         p = (c - 1) - idx * per;
         strobing = c < rdy_c && p >= 1 && p <= len;
         chk("nCE", nCE, !strobing);
         chk("nWE", nWE, !strobing);
         chk("D", D, exp_b[idx]);
         chk("busy", busy, c < rdy_c);
         chk("req_ready", req_ready, c == rdy_c);
         chk("err", err, tmo && c == rdy_c);
         READY = strobing ? (p > k) : 1'($urandom);
      end
   endtask

   initial begin
      nRST      = 1'b0;
      req_valid = 1'b0;
      req_chan  = 2'd0;
      req_vol   = 1'b0;
      req_data  = 10'd0;
      READY     = 1'b1;
      repeat (3) @(negedge CLK);
      chk("rst_nCE", nCE, 1);
      chk("rst_nWE", nWE, 1);
      chk("rst_D", D, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_req_ready", req_ready, 0);
      nRST = 1'b1;
      #1 chk("rel_req_ready", req_ready, 1);

      run_cmd(2'd0, 1'b0, 10'h3FE, 0);
      run_cmd(2'd2, 1'b1, 10'h005, 0);
      run_cmd(2'd3, 1'b0, 10'h3F5, 0);
      run_cmd(2'd1, 1'b0, 10'($urandom), 10);
      run_cmd(2'd1, 1'b0, 10'($urandom), 1000);
      run_cmd(2'd3, 1'b1, 10'($urandom), 0);
      for (int i = 0; i < 25; i++)
         run_cmd(2'($urandom), 1'($urandom), 10'($urandom), int'($urandom_range(0, 6)));

      // Reset during the first strobe of a tone write
      req_chan  = 2'd0;
      req_vol   = 1'b0;
      req_data  = 10'h3FE;
      req_valid = 1'b1;
      READY     = 1'b1;
      @(negedge CLK);
      req_valid = 1'b0;
      @(negedge CLK);
      chk("mid_nCE_low", nCE, 0);
      nRST = 1'b0;
      @(negedge CLK);
      chk("mid_rst_nCE", nCE, 1);
      chk("mid_rst_nWE", nWE, 1);
      chk("mid_rst_D", D, 8'h00);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_req_ready", req_ready, 0);
      nRST = 1'b1;
      #1 chk("mid_rel_req_ready", req_ready, 1);
      run_cmd(2'd2, 1'b1, 10'($urandom), 0);
      run_cmd(2'd0, 1'b0, 10'($urandom), 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
